test_pattern_gen: RTL and testbench

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

---
 rtl/tpg_pkg.sv | 58 +++++
 rtl/tpg_core.sv | 39 +++
 rtl/test_pattern_gen.sv | 124 ++++++++++++
 tb/tb_test_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// Shared definitions for the test pattern generator: mode encodings, LFSR tap
// masks per state width, the next-state rule and the output word builder.
// Functions operate on a 32-bit container. The active width is passed in as
// an argument, and bits above that width are always returned as zero.
package tpg_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR = 2'b00,
    MODE_CNT  = 2'b01,
    MODE_WALK = 2'b10,
    MODE_ADDR = 2'b11
  } tpg_mode_e;

  // Ones in the low w bits. A shift by 32 yields 0, so the result is all ones.
  function automatic logic [31:0] width_mask(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Maximal-length XNOR tap positions, zero-indexed, for each legal width.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;  // 7,5,4,3
      24:      return 32'h00E1_0000;  // 23,22,21,16
      32:      return 32'h8020_0003;  // 31,21,1,0
      default: return 32'h0000_D008;  // 15,14,12,3
    endcase
  endfunction

  // State after one advance in the given mode.
  function automatic logic [31:0] next_state(input logic [31:0] x,
                                             input tpg_mode_e   mode,
                                             input logic [31:0] addr_x,
                                             input int unsigned w);
    logic [31:0] nx;
    case (mode)
      MODE_LFSR: nx = {x[30:0], ~^(x & tap_mask(w))};
      MODE_CNT:  nx = x + 32'd1;
      MODE_WALK: nx = (x == 32'd0) ? 32'd1 : ((x << 1) | (x >> (w - 1)));
      default:   nx = addr_x;
    endcase
    return nx & width_mask(w);
  endfunction

  // Output word {x, rev(x), ~rev(x), ~x}, packed into the low 4*w bits.
  function automatic logic [127:0] build_word(input logic [31:0] x,
                                              input int unsigned w);
    logic [31:0] m;
    logic [31:0] r;
    m = width_mask(w);
    r = {<<{x}};
    r = r >> (32 - w);
    return ({96'd0, x}      << (3 * w)) |
           ({96'd0, r}      << (2 * w)) |
           ({96'd0, ~r & m} << w)       |
            {96'd0, ~x & m};
  endfunction

endpackage

// File: rtl/tpg_core.sv
// Pattern state register. The state reloads from the seed on request, or
// steps according to the current mode. The next state is also exported so the
// parent can detect a period without recomputing it.
module tpg_core
  import tpg_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              reload,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  output logic [LFSR_W-1:0] x,
  output logic [LFSR_W-1:0] x_next
);

  logic [LFSR_W-1:0] addr_x;

  // The address is zero-extended or truncated to the state width.
  assign addr_x = LFSR_W'(addr);
  assign x_next = LFSR_W'(next_state(32'(x), tpg_mode_e'(mode), 32'(addr_x), LFSR_W));

  // A reload has priority over a step; otherwise the state holds.
  // NOTE: non-blocking assignments make every register sample pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      x <= '0;
    end else if (reload) begin
      x <= seed;
    end else if (step) begin
      x <= x_next;
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern generator with a tristate read port, a word counter and a
// period pulse. Defining TPG_CHECKER_EN compiles in a second generator. That
// generator checks incoming CHK_DATA words and keeps a sticky error flag and a
// saturating error count.
module test_pattern_gen
  import tpg_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter int ADDR_W = 22
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic                CEb,
  input  logic                OEb,
  input  logic                REb,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [1:0]          MODE,
  input  logic                LOADb,
  input  logic [LFSR_W-1:0]   SEED,
  output wire  [4*LFSR_W-1:0] USER_DATA,
  output logic                PERIOD_DONE,
  output logic [31:0]         WORD_CNT,
  input  logic                CHK_VALID,
  input  logic [4*LFSR_W-1:0] CHK_DATA,
  output logic                ERR_FLAG,
  output logic [15:0]         ERR_CNT
);

  localparam int DATA_W = 4 * LFSR_W;

  tpg_mode_e         mode_q;
  logic [LFSR_W-1:0] seed_q;
  logic [LFSR_W-1:0] x;
  logic [LFSR_W-1:0] x_next;
  logic              load;
  logic              mode_change;
  logic              reload;
  logic              advance;

  // A load or a mode switch reloads the seed. In both cases that edge is not
  // an advance.
  assign load        = ~LOADb;
  assign mode_change = (MODE != mode_q);
  assign reload      = load | mode_change;
  assign advance     = ~CEb & ~REb & ~reload;

  // The read port is combinational from the registered state.
  assign USER_DATA = (~CEb & ~OEb) ? DATA_W'(build_word(32'(x), LFSR_W))
                                   : {DATA_W{1'bz}};

  tpg_core #(.LFSR_W(LFSR_W), .ADDR_W(ADDR_W)) u_core (
    .clk    (CLK),
    .resetB (RSTb),
    .reload (reload),
    .step   (advance),
    .seed   (SEED),
    .mode   (MODE),
    .addr   (ADDR),
    .x      (x),
    .x_next (x_next)
  );

  // Mode copy, last loaded seed, advance counter and period pulse.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      mode_q      <= MODE_LFSR;
      seed_q      <= '0;
      WORD_CNT    <= '0;
      PERIOD_DONE <= 1'b0;
    end else begin
      mode_q      <= tpg_mode_e'(MODE);
      PERIOD_DONE <= advance && (MODE != MODE_ADDR) && (x_next == seed_q);
      if (reload) seed_q <= SEED;
      if (load) begin
        WORD_CNT <= '0;
      end else if (advance) begin
        WORD_CNT <= WORD_CNT + 32'd1;
      end
    end
  end

`ifdef TPG_CHECKER_EN
  logic [LFSR_W-1:0] chk_x;
  logic [LFSR_W-1:0] unused_chk_next;
  logic [DATA_W-1:0] chk_word;

  tpg_core #(.LFSR_W(LFSR_W), .ADDR_W(ADDR_W)) u_chk (
    .clk    (CLK),
    .resetB (RSTb),
    .reload (reload),
    .step   (CHK_VALID),
    .seed   (SEED),
    .mode   (MODE),
    .addr   (ADDR),
    .x      (chk_x),
    .x_next (unused_chk_next)
  );

  assign chk_word = DATA_W'(build_word(32'(chk_x), LFSR_W));

  // Sticky error flag and saturating mismatch count. A load clears both.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ERR_FLAG <= 1'b0;
      ERR_CNT  <= '0;
    end else if (load) begin
      ERR_FLAG <= 1'b0;
      ERR_CNT  <= '0;
    end else if (CHK_VALID && (CHK_DATA != chk_word)) begin
      ERR_FLAG <= 1'b1;
      if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
    end
  end
`else
  logic unused_chk;

  // Without the checker, the check inputs are ignored and the error outputs
  // stay at zero.
  assign unused_chk = ^{CHK_VALID, CHK_DATA};
  assign ERR_FLAG   = 1'b0;
  assign ERR_CNT    = '0;
`endif

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen using the default parameters (16-bit state).
// A reference model computes each expected word from the generator rules
// using integer arithmetic. A pull-up on the data bus makes a released bus
// read as all ones. A driven word can never be all ones, because it contains
// both x and ~x.
module tb_test_pattern_gen;

  localparam int LFSR_W = 16;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              ceb = 1'b1;
  logic              oeb = 1'b1;
  logic              reb = 1'b1;
  logic              loadb = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [1:0]        mode = 2'b00;
  logic [15:0]       seed = '0;
  logic              chk_valid = 1'b0;
  logic [63:0]       chk_data = '0;
  tri1  [63:0]       user_data;
  logic              period_done;
  logic [31:0]       word_cnt;
  logic              err_flag;
  logic [15:0]       err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int unsigned m_x, m_seed, m_cx, m_cnt, m_ecnt;
  int          m_mode;
  bit          m_pd, m_err;

  always #5 clk = ~clk;

  test_pattern_gen #(.LFSR_W(LFSR_W), .ADDR_W(ADDR_W)) dut (
    .CLK         (clk),
    .RSTb        (rstb),
    .CEb         (ceb),
    .OEb         (oeb),
    .REb         (reb),
    .ADDR        (addr),
    .MODE        (mode),
    .LOADb       (loadb),
    .SEED        (seed),
    .USER_DATA   (user_data),
    .PERIOD_DONE (period_done),
    .WORD_CNT    (word_cnt),
    .CHK_VALID   (chk_valid),
    .CHK_DATA    (chk_data),
    .ERR_FLAG    (err_flag),
    .ERR_CNT     (err_cnt)
  );

  function automatic logic [63:0] ref_word(input int unsigned x);
    logic [15:0] xv, rv;
    xv = 16'(x);
    rv = '0;
    for (int i = 0; i < 16; i++) rv[15-i] = xv[i];
    return {xv, rv, ~rv, ~xv};
  endfunction

  function automatic int unsigned ref_next(input int unsigned x, input int md,
                                           input int unsigned a);
    int unsigned fb;
    case (md)
      0: begin
        fb = 1 ^ (((x >> 15) ^ (x >> 14) ^ (x >> 12) ^ (x >> 3)) & 1);
        return (x * 2 + fb) % 65536;
      end
      1:       return (x + 1) % 65536;
      2:       return (x == 0) ? 1 : (x * 2) % 65536 + x / 32768;
      default: return a % 65536;
    endcase
  endfunction

  function automatic void model_reset();
    m_x = 0; m_seed = 0; m_cx = 0; m_cnt = 0; m_ecnt = 0;
    m_mode = 0; m_pd = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    bit ld, mchg, adv;
    int unsigned nx, cnx;
    ld   = !loadb;
    mchg = (int'(mode) != m_mode);
    adv  = !ceb && !reb && !ld && !mchg;
    nx   = ref_next(m_x, int'(mode), int'(addr));
    cnx  = ref_next(m_cx, int'(mode), int'(addr));
    m_pd = adv && (mode != 2'b11) && (nx == m_seed);
`ifdef TPG_CHECKER_EN
    if (ld) begin
      m_err = 0; m_ecnt = 0;
    end else if (chk_valid && (chk_data !== ref_word(m_cx))) begin
      m_err = 1;
      if (m_ecnt < 65535) m_ecnt++;
    end
`endif
    if (ld || mchg) m_cx = seed;
    else if (chk_valid) m_cx = cnx;
    if (ld || mchg) begin
      m_x = seed; m_seed = seed;
    end else if (adv) begin
      m_x = nx;
    end
    if (ld) m_cnt = 0;
    else if (adv) m_cnt++;
    m_mode = int'(mode);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] exp_data;
    exp_data = (!ceb && !oeb) ? ref_word(m_x) : {64{1'b1}};
    check({tag, " data"}, user_data, exp_data);
    check({tag, " word_cnt"}, 64'(word_cnt), 64'(m_cnt));
    check({tag, " period_done"}, 64'(period_done), 64'(m_pd));
    check({tag, " err_flag"}, 64'(err_flag), 64'(m_err));
    check({tag, " err_cnt"}, 64'(err_cnt), 64'(m_ecnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int unsigned seq[4];
    int pulses;
    seq = '{32'h0003, 32'h0007, 32'h000F, 32'h001E};

    // Reset state with the bus enabled.
    model_reset();
    #2;
    ceb = 1'b0; oeb = 1'b0;
    #1;
    check_all("reset");
    check("reset word", user_data, 64'h0000_0000_FFFF_FFFF);

    // First advance from reset, then the start of the LFSR sequence.
    @(negedge clk);
    rstb = 1'b1;
    reb  = 1'b0;
    tick("adv1");
    check("first word", user_data, 64'h0001_8000_7FFF_FFFE);
    check("first cnt", 64'(word_cnt), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick("lfsr seq");
      check("lfsr x", 64'(user_data[63:48]), 64'(seq[i]));
    end

    // A reset mid-sequence restarts from the power-up state.
    rstb = 1'b0;
    #1;
    model_reset();
    check_all("mid reset");
    @(negedge clk);
    rstb = 1'b1;
    tick("after reset");
    check("restart word", user_data, 64'h0001_8000_7FFF_FFFE);

    // Complete the 65535-advance period and expect exactly one pulse.
    pulses = 0;
    for (int i = 0; i < 65534; i++) begin
      tick("period");
      if (period_done === 1'b1) pulses++;
    end
    check("period pulses", 64'(pulses), 64'd1);
    check("period end x", 64'(user_data[63:48]), 64'h0000);
    tick("period after");

    // Counter mode wraps from all ones to zero.
    mode = 2'b01; loadb = 1'b0; seed = 16'hFFFE;
    tick("cnt load");
    check("cnt load cnt", 64'(word_cnt), 64'd0);
    loadb = 1'b1;
    tick("cnt1");
    check("cnt x ffff", 64'(user_data[63:48]), 64'hFFFF);
    tick("cnt2");
    check("cnt x 0000", 64'(user_data[63:48]), 64'h0000);
    check("cnt word_cnt", 64'(word_cnt), 64'd2);

    // With the output disabled the bus floats, but the state still advances.
    oeb = 1'b1;
    tick("oe off");
    check("hiz bus", user_data, {64{1'b1}});
    oeb = 1'b0;
    #1;
    check_all("oe on");
    check("hiz advanced", 64'(user_data[63:48]), 64'h0001);

    // A load wins over a simultaneous read strobe.
    loadb = 1'b0; seed = 16'h1234;
    tick("load vs re");
    check("load x", 64'(user_data[63:48]), 64'h1234);
    check("load cnt", 64'(word_cnt), 64'd0);

    // A mode change reloads the seed without advancing.
    loadb = 1'b1; mode = 2'b00;
    tick("chg to lfsr");
    tick("lfsr a");
    tick("lfsr b");
    mode = 2'b10; seed = 16'h0000;
    tick("chg to walk");
    check("chg x", 64'(user_data[63:48]), 64'h0000);
    check("chg cnt", 64'(word_cnt), 64'd2);
    tick("walk1");
    check("walk x", 64'(user_data[63:48]), 64'h0001);
    check("walk cnt", 64'(word_cnt), 64'd3);

`ifdef TPG_CHECKER_EN
    // Ten checked words, with the fourth word corrupted.
    ceb = 1'b1; reb = 1'b1; mode = 2'b00; loadb = 1'b0; seed = 16'hACE1;
    tick("chk load");
    loadb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_valid = 1'b1;
      chk_data  = ref_word(m_cx) ^ ((i == 3) ? 64'h0000_0000_0000_0020 : 64'h0);
      tick("chk word");
    end
    chk_valid = 1'b0;
    check("chk flag", 64'(err_flag), 64'd1);
    check("chk cnt", 64'(err_cnt), 64'd1);
    loadb = 1'b0;
    tick("chk clear");
    check("chk flag clr", 64'(err_flag), 64'd0);
    check("chk cnt clr", 64'(err_cnt), 64'd0);
    loadb = 1'b1;
`else
    // Without the checker, check traffic has no effect on the error outputs.
    ceb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_valid = 1'b1;
      chk_data  = {$urandom, $urandom};
      tick("chk ignored");
    end
    chk_valid = 1'b0;
    check("no chk flag", 64'(err_flag), 64'd0);
    check("no chk cnt", 64'(err_cnt), 64'd0);
`endif

    // Randomised traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      ceb       = ($urandom_range(3) == 0);
      reb       = ($urandom_range(3) == 0);
      oeb       = $urandom_range(1) == 1;
      loadb     = ($urandom_range(15) != 0);
      if ($urandom_range(15) == 0) mode = 2'($urandom);
      seed      = 16'($urandom);
      addr      = ADDR_W'($urandom);
      chk_valid = $urandom_range(1) == 1;
      chk_data  = ref_word(m_cx) ^ (($urandom_range(7) == 0) ? 64'h1 << $urandom_range(63) : 64'h0);
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
